// File: rtl/imul2_lut_sequencer_pkg.sv
// Shared IMUL2 definitions: opcode, sequencer state encodings and default operand width.
package imul2_lut_sequencer_pkg;

    localparam logic [7:0]  OPC_IMUL2     = 8'h2A;
    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IMUL_IDLE = 2'd0,
        IMUL_RUN  = 2'd1,
        IMUL_DONE = 2'd2
    } imul_state_e;

endpackage

// File: rtl/imul2_lut_sequencer_multiple_lut.sv
// Radix-4 multiple select: picks 0, A, 2A or the precomputed 3A for one digit of B.
module imul2_multiple_lut
    import imul2_lut_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [1:0]       digit_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH+1:0] a3_i,
    output logic [WIDTH+1:0] mult_o
);

    always_comb begin
        mult_o = '0;
        case (digit_i)
            2'd0: mult_o = '0;
            2'd1: mult_o = {2'b00, a_i};
            2'd2: mult_o = {1'b0, a_i, 1'b0};
            2'd3: mult_o = a3_i;
            default: mult_o = '0;
        endcase
    end

endmodule

// File: rtl/imul2_lut_sequencer.sv
// IMUL2 sequencer: fixed-latency radix-4 unsigned multiply, stalls fetch until write-back.
module imul2_lut_sequencer
    import imul2_lut_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 iStart,
    input  logic [WIDTH-1:0]     iA,
    input  logic [WIDTH-1:0]     iB,
    input  logic [7:0]           iDestination,
    output logic                 oStall,
    output logic                 oBusy,
    output logic                 oDone,
    output logic [2*WIDTH-1:0]   oResult,
    output logic [7:0]           oDestination
);

    localparam int unsigned ITER  = WIDTH / 2;
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    imul_state_e        state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH+1:0]   a3_q;
    logic [WIDTH+1:0]   a3_d;
    logic [PW-1:0]      acc_q;
    logic [PW-1:0]      acc_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [7:0]         dest_q;
    logic               busy_q;
    logic               done_q;
    logic [PW-1:0]      result_q;
    logic [7:0]         dest_out_q;
    logic [WIDTH+1:0]   mult;

    imul2_multiple_lut #(
        .WIDTH (WIDTH)
    ) u_lut (
        .digit_i (b_q[1:0]),
        .a_i     (a_q),
        .a3_i    (a3_q),
        .mult_o  (mult)
    );

    always_comb begin
        a3_d  = {2'b00, iA} + {1'b0, iA, 1'b0};
        acc_d = acc_q + (PW'(mult) << {cnt_q, 1'b0});
    end

    // Stall must cover the accept cycle itself, before the state register moves.
    assign oStall = ((state_q == IMUL_IDLE) && iStart) || (state_q == IMUL_RUN);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= IMUL_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            a3_q       <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            dest_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            dest_out_q <= '0;
        end else begin
            case (state_q)
                IMUL_IDLE: begin
                    done_q <= 1'b0;
                    if (iStart) begin
                        a_q     <= iA;
                        b_q     <= iB;
                        a3_q    <= a3_d;
                        dest_q  <= iDestination;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= IMUL_RUN;
                    end
                end
                IMUL_RUN: begin
                    acc_q <= acc_d;
                    b_q   <= b_q >> 2;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        result_q   <= acc_d;
                        dest_out_q <= dest_q;
                        done_q     <= 1'b1;
                        state_q    <= IMUL_DONE;
                    end
                end
                IMUL_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IMUL_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IMUL_IDLE;
                end
            endcase
        end
    end

    assign oBusy        = busy_q;
    assign oDone        = done_q;
    assign oResult      = result_q;
    assign oDestination = dest_out_q;

endmodule

// File: tb/tb_imul2_lut_sequencer.sv
// Directed bench for imul2_lut_sequencer: vector table plus back-to-back, reset and hold sequences.
module tb_imul2_lut_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        iStart;
    logic [15:0] iA;
    logic [15:0] iB;
    logic [7:0]  iDestination;
    logic        oStall;
    logic        oBusy;
    logic        oDone;
    logic [31:0] oResult;
    logic [7:0]  oDestination;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  dest;
        logic [31:0] prod;
    } vec_t;

    vec_t vecs[7];

    imul2_lut_sequencer #(
        .WIDTH (16)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iStart       (iStart),
        .iA           (iA),
        .iB           (iB),
        .iDestination (iDestination),
        .oStall       (oStall),
        .oBusy        (oBusy),
        .oDone        (oDone),
        .oResult      (oResult),
        .oDestination (oDestination)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Accept in cycle N, expect stall through N+8 and the done pulse at N+9.
    task automatic run_mul(input vec_t v);
        @(negedge Clock);
        iA = v.a; iB = v.b; iDestination = v.dest; iStart = 1'b1;
        #1;
        chk("stall_accept", oStall, 1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge Clock);
            iStart = 1'b0;
            iA = ~iA;
            iB = iB ^ 16'h5A5A;
            iDestination = ~iDestination;
            #1;
            chk("stall_run", oStall, 1);
            chk("done_early", oDone, 0);
            chk("busy_run", oBusy, 1);
        end
        @(negedge Clock);
        #1;
        chk("done_pulse", oDone, 1);
        chk("stall_done", oStall, 0);
        chk("busy_done", oBusy, 1);
        chk("result", oResult, v.prod);
        chk("dest", oDestination, 32'(v.dest));
        @(negedge Clock);
        #1;
        chk("done_drop", oDone, 0);
        chk("busy_idle", oBusy, 0);
        chk("result_kept", oResult, v.prod);
    endtask

    initial begin
        vecs[0] = '{a: 16'd7,    b: 16'd9,    dest: 8'd3,    prod: 32'd63};
        vecs[1] = '{a: 16'hFFFF, b: 16'hFFFF, dest: 8'h11,   prod: 32'hFFFE0001};
        vecs[2] = '{a: 16'h1234, b: 16'h0000, dest: 8'd4,    prod: 32'd0};
        vecs[3] = '{a: 16'h0000, b: 16'hBEEF, dest: 8'd5,    prod: 32'd0};
        vecs[4] = '{a: 16'h00FF, b: 16'h0100, dest: 8'hA0,   prod: 32'h0000FF00};
        vecs[5] = '{a: 16'hABCD, b: 16'h0002, dest: 8'hFF,   prod: 32'h0001579A};
        vecs[6] = '{a: 16'h8000, b: 16'h8000, dest: 8'h42,   prod: 32'h40000000};

        Reset = 1'b1; iStart = 1'b0; iA = '0; iB = '0; iDestination = '0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        #1;
        chk("rst_stall", oStall, 0);
        chk("rst_busy", oBusy, 0);
        chk("rst_done", oDone, 0);
        chk("rst_result", oResult, 0);
        chk("rst_dest", oDestination, 0);
        Reset = 1'b0;

        for (int i = 0; i < 7; i++) run_mul(vecs[i]);

        // Result hold with toggling operands and no start.
        run_mul(vecs[0]);
        for (int k = 0; k < 20; k++) begin
            @(negedge Clock);
            iA = 16'(k * 16'h1357); iB = ~iA;
            #1;
            chk("hold_result", oResult, 63);
            chk("hold_done", oDone, 0);
            chk("hold_stall", oStall, 0);
        end

        // Back-to-back: iStart held high through RUN and DONE.
        @(negedge Clock);
        iA = 16'd5; iB = 16'd6; iDestination = 8'd7; iStart = 1'b1;
        #1;
        chk("b2b_stall_acc1", oStall, 1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge Clock);
            iA = 16'd100; iB = 16'd100; iDestination = 8'd8;
            #1;
            chk("b2b_stall_run1", oStall, 1);
            chk("b2b_done_early1", oDone, 0);
        end
        @(negedge Clock);
        #1;
        chk("b2b_done1", oDone, 1);
        chk("b2b_result1", oResult, 30);
        chk("b2b_dest1", oDestination, 7);
        chk("b2b_stall_done1", oStall, 0);
        @(negedge Clock);
        #1;
        chk("b2b_stall_acc2", oStall, 1);
        chk("b2b_done_idle", oDone, 0);
        chk("b2b_busy_idle", oBusy, 0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge Clock);
            iStart = 1'b0;
            #1;
            chk("b2b_stall_run2", oStall, 1);
            chk("b2b_done_early2", oDone, 0);
            chk("b2b_result_held", oResult, 30);
        end
        @(negedge Clock);
        #1;
        chk("b2b_done2", oDone, 1);
        chk("b2b_result2", oResult, 10000);
        chk("b2b_dest2", oDestination, 8);

        // Reset during RUN at cycle N+4.
        @(negedge Clock);
        @(negedge Clock);
        iA = 16'd3; iB = 16'd3; iDestination = 8'd9; iStart = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clock);
            iStart = 1'b0;
            if (k == 4) Reset = 1'b1;
        end
        @(negedge Clock);
        #1;
        chk("mid_rst_stall", oStall, 0);
        chk("mid_rst_busy", oBusy, 0);
        chk("mid_rst_done", oDone, 0);
        chk("mid_rst_result", oResult, 0);
        chk("mid_rst_dest", oDestination, 0);
        Reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clock);
            #1;
            chk("mid_rst_no_done", oDone, 0);
            chk("mid_rst_no_stall", oStall, 0);
        end
        run_mul('{a: 16'd2, b: 16'd2, dest: 8'd10, prod: 32'd4});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
